spi_slave_param: RTL
====================

// Module: spi_slave_param
// PURPOSE
//  Parametrised SPI slave: frames serial MOSI into (DATA_W+2)-bit {cmd[1:0],payload} words for a RAM/regfile.
//  Returns DATA_W-bit read data on MISO, with a bounded wait for tx_valid and abort on SS_n deassert.
//  Sits between the SPI pins and the memory-side controller; clk is the serial bit clock (one bit per edge).
// PARAMETERS
//  DATA_W       8   payload/read-data width; frame width RX_W = DATA_W+2 (localparam)
//  TX_WAIT_MAX  16  max cycles in WAIT_TX for tx_valid before abort to IDLE (>=1)
// PORTS
//  clk       in   1        clock, all state updates on posedge
//  rst       in   1        asynchronous, active-low reset
//  SS_n      in   1        slave select, active-low
//  MOSI      in   1        serial data in, MSB first
//  tx_valid  in   1        tx_data valid (sampled only in WAIT_TX)
//  tx_data   in   DATA_W   read data to return to master
//  MISO      out  1        serial data out, MSB first; 0 when not transmitting
//  rx_valid  out  1        one-cycle pulse: rx_data holds a complete frame
//  rx_data   out  DATA_W+2 received frame {cmd[1:0], payload}
//  rx_err    out  1        one-cycle pulse on parity failure (PARITY_CHK_EN); else tied 0
//  busy      out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; MISO, rx_valid, rx_err, busy=0; rx_data, counter, shift reg=0.
//  States: IDLE, CHK_CMD, RX, WAIT_TX, TX. Clock edges below are posedges.
//  IDLE: SS_n=0 -> CHK_CMD; rx_data cleared to 0 on this transition.
//  CHK_CMD: sample MOSI as mode bit (not stored): 1 = read path, 0 = write path; -> RX, counter=0.
//  RX: shift MOSI into rx_data LSB ({rx_data[RX_W-2:0],MOSI}), counter++ per edge, RX_W edges total.
//   On the edge shifting in the last bit: rx_valid=1 (exactly one cycle; rx_data already complete).
//   Next state: read path AND received cmd==2'b11 -> WAIT_TX; otherwise -> IDLE.
//   cmd==2'b11 on the write path: rx_valid still pulses, no read follows.
//  WAIT_TX: wait counter counts up from 0. tx_valid=1 -> latch tx_data into shift reg, -> TX.
//   Counter reaches TX_WAIT_MAX without tx_valid -> IDLE, MISO stays 0, no output pulses.
//  TX: MISO <= shift_reg[DATA_W-1], shift left, DATA_W edges; first bit visible the cycle after latch.
//   After the last bit: MISO=0, -> IDLE.
//  rx_data holds its value after a frame until the next IDLE->CHK_CMD transition.
//  SS_n=1 in any non-IDLE state: -> IDLE next edge, counters cleared, MISO=0.
//   Partial frame never raises rx_valid; this rule has priority over all other transitions.
//  tx_valid outside WAIT_TX: ignored. SS_n stays low after a frame: IDLE -> CHK_CMD next edge (back-to-back).
//  Reset mid-operation: all outputs to reset values immediately, regardless of state.
// CONFIGURATION
//  `PARITY_CHK_EN defined:
//   RX takes RX_W+1 edges; the extra trailing bit is even parity over the RX_W frame bits.
//   On the parity edge: match -> rx_valid pulse; mismatch -> rx_err pulse, no rx_valid, -> IDLE.
//  `PARITY_CHK_EN undefined:
//   No parity bit; rx_valid on the RX_W-th edge as above; rx_err tied to 0.
// TESTING (DATA_W=8, TX_WAIT_MAX=16, macro undefined unless stated)
//  1 Write: SS_n=0, mode 0, bits 00_1010_0101 -> single rx_valid with rx_data=10'h0A5; MISO=0; IDLE.
//  2 Read: mode1+10'h233 -> rx_valid, rx_data=0x233, IDLE; then mode1+10'h300 -> WAIT_TX.
//    tx_valid with tx_data=0xC3 3 cycles later -> MISO=1,1,0,0,0,0,1,1 on 8 consecutive cycles, then 0.
//  3 Timeout: read-data frame (mode1, cmd 11), no tx_valid -> IDLE after 16 cycles; MISO 0; busy falls.
//  4 Abort: SS_n=1 after 5 data bits -> no rx_valid, IDLE next edge; next full frame decodes correctly.
//  5 Async reset: rst=0 mid-TX (bit 4) -> MISO, busy, rx_valid=0 without waiting for a clock edge.
//  6 PARITY_CHK_EN: frame 10'h0A5 + parity bit 1 (wrong) -> rx_err pulse, no rx_valid.
//    Same frame + parity bit 0 -> rx_valid pulse.

Source files
------------

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave that frames serial MOSI into {cmd[1:0], payload}
// words and, for read commands, returns DATA_W bits of read data on MISO.
// clk is the serial bit clock; one bit moves per rising edge.
// Optional feature: define PARITY_CHK_EN to append and check a trailing even
// parity bit after each received frame.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int TX_WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_err,
  output logic              busy
);

  localparam int RX_W = DATA_W + 2;
`ifdef PARITY_CHK_EN
  localparam int RX_EDGES = RX_W + 1;
`else
  localparam int RX_EDGES = RX_W;
`endif
  // One shared counter serves RX, WAIT_TX and TX, so size it for the longest.
  localparam int TOP_A   = (RX_EDGES > TX_WAIT_MAX) ? RX_EDGES : TX_WAIT_MAX;
  localparam int CNT_TOP = (TOP_A > DATA_W + 1) ? TOP_A : DATA_W + 1;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    RX,
    WAIT_TX,
    TX
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              read_mode;

  // busy is a direct decode of the state register
  assign busy = (state != IDLE);

  // Main protocol FSM; SS_n deassertion aborts from any active state first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      read_mode <= 1'b0;
      MISO      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      rx_data   <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (state != IDLE && SS_n) begin
        state <= IDLE;
        cnt   <= '0;
        MISO  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) begin
              state   <= CHK_CMD;
              rx_data <= '0;
              cnt     <= '0;
            end
          end
          CHK_CMD: begin
            read_mode <= MOSI;
            state     <= RX;
            cnt       <= '0;
          end
          RX: begin
`ifdef PARITY_CHK_EN
            if (cnt == CNT_W'(RX_W)) begin
              cnt <= '0;
              if ((^rx_data) == MOSI) begin
                rx_valid <= 1'b1;
                state    <= (read_mode && rx_data[RX_W-1 -: 2] == 2'b11) ? WAIT_TX : IDLE;
              end else begin
                rx_err <= 1'b1;
                state  <= IDLE;
              end
            end else begin
              rx_data <= {rx_data[RX_W-2:0], MOSI};
              cnt     <= cnt + CNT_W'(1);
            end
`else
            rx_data <= {rx_data[RX_W-2:0], MOSI};
            if (cnt == CNT_W'(RX_W - 1)) begin
              cnt      <= '0;
              rx_valid <= 1'b1;
              state    <= (read_mode && rx_data[RX_W-2 -: 2] == 2'b11) ? WAIT_TX : IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
`endif
          end
          WAIT_TX: begin
            if (tx_valid) begin
              shift_reg <= tx_data;
              state     <= TX;
              cnt       <= '0;
            end else if (cnt == CNT_W'(TX_WAIT_MAX - 1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          TX: begin
            if (cnt == CNT_W'(DATA_W)) begin
              MISO  <= 1'b0;
              state <= IDLE;
              cnt   <= '0;
            end else begin
              MISO      <= shift_reg[DATA_W-1];
              shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
              cnt       <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            MISO  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
